// File: rtl/main_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_pkg
// Brief    : Shared state encoding and default geometry for the main memory
//            controller.
// Revision : 1.0
// ============================================================================
package main_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WB_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_FILL    = 2'd3
    } state_t;

    localparam int c_BLOCK_WORDS  = 16;
    localparam int c_OFFSET_WIDTH = 6;
    localparam int c_LATENCY      = 4;
    // Latency counter holds LATENCY-1, and LATENCY never exceeds 15.
    localparam int c_CNT_WIDTH    = 4;

endpackage : main_mem_pkg
`default_nettype wire

// File: rtl/mem_block_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_array
// Brief    : Synchronous single-port block-wide storage, no reset.
// Revision : 1.0
// ============================================================================
module mem_block_array
    import main_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = c_BLOCK_WORDS,
    parameter int MEM_BLOCKS  = 1024,
    parameter int IDX_WIDTH   = $clog2(MEM_BLOCKS)
) (
    input  logic                                  clk,
    input  logic                                  i_we,
    input  logic [IDX_WIDTH-1:0]                  i_idx,
    input  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] i_wdata,
    output logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] o_rdata
);

    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] r_mem_q [MEM_BLOCKS];
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] r_rdata_q;

    // Read port holds its last value on a write cycle (single port).
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_idx] <= i_wdata;
        end else begin
            r_rdata_q <= r_mem_q[i_idx];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule : mem_block_array
`default_nettype wire

// File: rtl/main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_ctrl
// Brief    : Fixed-latency main memory behind a cache: one-entry writeback
//            buffer, prioritised drain, block refill with a one-cycle pulse.
// Revision : 1.0
// ============================================================================
module main_mem_ctrl
    import main_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int OFFSET_WIDTH  = c_OFFSET_WIDTH,
    parameter int BLOCK_WORDS   = c_BLOCK_WORDS,
    parameter int MEM_BLOCKS    = 1024,
    parameter int LATENCY       = c_LATENCY
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wb_valid,
    input  logic [ADDRESS_WIDTH-1:0]               wb_addr,
    input  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] wb_data,
    input  logic                                   rd_req,
    input  logic [ADDRESS_WIDTH-1:0]               rd_addr,
    output logic                                   fill_valid,
    output logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] fill_data,
    output logic                                   busy,
    output logic                                   wb_overflow
);

    localparam int c_IDX_WIDTH = $clog2(MEM_BLOCKS);
    localparam logic [c_CNT_WIDTH-1:0] c_CNT_LOAD = c_CNT_WIDTH'(LATENCY - 1);

    typedef logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] block_t;

    state_t                   r_state_q,       w_state_d;
    logic [c_CNT_WIDTH-1:0]   r_cnt_q,         w_cnt_d;
    logic [c_IDX_WIDTH-1:0]   r_rd_idx_q,      w_rd_idx_d;
    logic                     r_wb_full_q,     w_wb_full_d;
    logic [c_IDX_WIDTH-1:0]   r_wb_idx_q,      w_wb_idx_d;
    block_t                   r_wb_data_q,     w_wb_data_d;
    logic                     r_fill_valid_q,  w_fill_valid_d;
    block_t                   r_fill_data_q,   w_fill_data_d;
    logic                     r_busy_q,        w_busy_d;
    logic                     r_wb_overflow_q, w_wb_overflow_d;

    logic [c_IDX_WIDTH-1:0]   w_rd_idx;
    logic [c_IDX_WIDTH-1:0]   w_wb_idx;
    logic                     w_drain;
    logic                     w_mem_we;
    logic [c_IDX_WIDTH-1:0]   w_mem_idx;
    block_t                   w_mem_rdata;
    logic                     w_unused;

    assign w_rd_idx = rd_addr[OFFSET_WIDTH +: c_IDX_WIDTH];
    assign w_wb_idx = wb_addr[OFFSET_WIDTH +: c_IDX_WIDTH];
    assign w_unused = ^{rd_addr, wb_addr};

    assign w_drain  = (r_state_q == ST_WB_WAIT) && (r_cnt_q == '0);
    assign w_mem_we = w_drain && !reset;

    // The array is read every non-write cycle; in RD_WAIT at count 0 the port
    // already holds the block addressed on the previous cycle.
    assign w_mem_idx = w_drain                    ? r_wb_idx_q :
                       (r_state_q == ST_RD_WAIT)  ? r_rd_idx_q : w_rd_idx;

    always_comb begin
        w_state_d       = r_state_q;
        w_cnt_d         = r_cnt_q;
        w_rd_idx_d      = r_rd_idx_q;
        w_wb_full_d     = r_wb_full_q;
        w_wb_idx_d      = r_wb_idx_q;
        w_wb_data_d     = r_wb_data_q;
        w_fill_data_d   = r_fill_data_q;
        w_wb_overflow_d = r_wb_overflow_q;

        if (wb_valid && (!r_wb_full_q || w_drain)) begin
            w_wb_full_d = 1'b1;
            w_wb_idx_d  = w_wb_idx;
            w_wb_data_d = wb_data;
        end else begin
            if (w_drain) begin
                w_wb_full_d = 1'b0;
            end
            if (wb_valid) begin
                w_wb_overflow_d = 1'b1;
            end
        end

        case (r_state_q)
            ST_IDLE: begin
                // A writeback arriving this cycle also wins, so a read issued
                // alongside it observes the new block.
                if (r_wb_full_q || wb_valid) begin
                    w_state_d = ST_WB_WAIT;
                    w_cnt_d   = c_CNT_LOAD;
                end else if (rd_req) begin
                    w_state_d  = ST_RD_WAIT;
                    w_cnt_d    = c_CNT_LOAD;
                    w_rd_idx_d = w_rd_idx;
                end
            end
            ST_WB_WAIT: begin
                if (r_cnt_q == '0) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt_q == '0) begin
                    w_state_d     = ST_FILL;
                    w_fill_data_d = w_mem_rdata;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            ST_FILL: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_fill_valid_d = (w_state_d == ST_FILL);
        w_busy_d       = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q       <= ST_IDLE;
            r_cnt_q         <= '0;
            r_rd_idx_q      <= '0;
            r_wb_full_q     <= 1'b0;
            r_wb_idx_q      <= '0;
            r_wb_data_q     <= '0;
            r_fill_valid_q  <= 1'b0;
            r_fill_data_q   <= '0;
            r_busy_q        <= 1'b0;
            r_wb_overflow_q <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_cnt_q         <= w_cnt_d;
            r_rd_idx_q      <= w_rd_idx_d;
            r_wb_full_q     <= w_wb_full_d;
            r_wb_idx_q      <= w_wb_idx_d;
            r_wb_data_q     <= w_wb_data_d;
            r_fill_valid_q  <= w_fill_valid_d;
            r_fill_data_q   <= w_fill_data_d;
            r_busy_q        <= w_busy_d;
            r_wb_overflow_q <= w_wb_overflow_d;
        end
    end

    mem_block_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BLOCK_WORDS (BLOCK_WORDS),
        .MEM_BLOCKS  (MEM_BLOCKS),
        .IDX_WIDTH   (c_IDX_WIDTH)
    ) u_mem_block_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_idx   (w_mem_idx),
        .i_wdata (r_wb_data_q),
        .o_rdata (w_mem_rdata)
    );

    assign fill_valid  = r_fill_valid_q;
    assign fill_data   = r_fill_data_q;
    assign busy        = r_busy_q;
    assign wb_overflow = r_wb_overflow_q;

endmodule : main_mem_ctrl
`default_nettype wire

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH 32, byte address width; DATA_WIDTH 32, word width; OFFSET_WIDTH 6, block byte-offset bits; BLOCK_WORDS 16, words per block; MEM_BLOCKS 1024, stored blocks; LATENCY 4, array access cycles, legal range 1..15.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wb_valid  input  1  one-cycle writeback pulse from cache.
REQ-005 wb_addr  input  ADDRESS_WIDTH  writeback block address; offset bits ignored.
REQ-006 wb_data  input  DATA_WIDTH x BLOCK_WORDS  writeback block, word 0 first.
REQ-007 rd_req  input  1  refill request level; requester holds it until fill_valid.
REQ-008 rd_addr  input  ADDRESS_WIDTH  refill block address, stable while rd_req=1.
REQ-009 fill_valid  output  1  one-cycle pulse; fill_data is valid in that cycle; drives cache refill-write enable.
REQ-010 fill_data  output  DATA_WIDTH x BLOCK_WORDS  refill block.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 wb_overflow  output  1  sticky error flag: writeback lost.

Function
REQ-013 Block index SHALL be addr[OFFSET_WIDTH+$clog2(MEM_BLOCKS)-1 : OFFSET_WIDTH]; upper address bits ignored (aliasing).
REQ-014 A one-entry writeback buffer (addr + data + full flag) SHALL capture every wb_valid pulse, in any state.
REQ-015 wb_valid while the buffer is full and not draining that cycle SHALL drop the new block and set wb_overflow.
REQ-016 FSM states SHALL be IDLE, WB_WAIT, RD_WAIT, FILL.
REQ-017 IDLE: buffer full -> WB_WAIT; else rd_req=1 -> RD_WAIT; else stay. Writeback has priority over a read.
REQ-018 On entry to WB_WAIT or RD_WAIT, a latency counter SHALL load LATENCY-1 and decrement each cycle.
REQ-019 WB_WAIT at count 0: write buffer into the array, clear the buffer flag, go to IDLE.
REQ-020 RD_WAIT at count 0: latch array block at rd_addr into fill_data, go to FILL.
REQ-021 FILL: assert fill_valid for exactly one cycle, go to IDLE; fill_data holds until the next fill.
REQ-022 A read SHALL return data of any writeback captured before the read was accepted (priority drain gives read-after-writeback ordering).
REQ-023 A writeback captured during RD_WAIT/FILL SHALL NOT alter the in-flight fill_data.
REQ-024 wb_valid in the cycle the buffer drains SHALL be captured without overflow.
REQ-025 Latency: read accepted in IDLE at cycle t, no pending writeback -> fill_valid at cycle t+LATENCY+1.
REQ-026 rd_req deasserted mid-read SHALL still complete the fill pulse; no abort.

Reset
REQ-027 Reset SHALL force state IDLE, counter 0, buffer empty, fill_valid 0, fill_data 0, busy 0, wb_overflow 0.
REQ-028 Reset mid-operation SHALL discard the in-flight read and any buffered writeback, with no array write.
REQ-029 Array contents SHALL NOT be reset.

Structure
REQ-030 Package main_mem_pkg SHALL hold the state enum and the default BLOCK_WORDS, OFFSET_WIDTH and LATENCY constants.
REQ-031 Storage SHALL be one sub-module, mem_block_array: synchronous single-port, block-wide read/write, no reset.

Verification
REQ-032 Write 0xA5A5_0000+i to block 0x0000_1040 word i -> read 0x0000_1040 returns the same words; fill_valid exactly 5 cycles after rd_req seen in IDLE.
REQ-033 Same-cycle wb_valid (addr 0x80, data 0x11...) and rd_req (addr 0x80) -> fill_data = 0x11...; fill_valid at t+10.
REQ-034 Two wb_valid pulses 1 cycle apart while in RD_WAIT -> wb_overflow=1; second block absent from array.
REQ-035 Reset asserted in RD_WAIT count 2 -> no fill_valid; busy=0 next cycle; prior array data intact.
REQ-036 Addresses 0x0000_0040 and 0x0001_0040 (aliasing, MEM_BLOCKS 1024) -> write one, read other, data matches.
REQ-037 rd_req dropped after acceptance -> single fill_valid pulse; FSM returns to IDLE.
